// File: rtl/cpu_pkg.sv
// Shared definitions for the store path: bus mode codes, FSM encoding and
// the source-select validity check.
package cpu_pkg;

  localparam logic [1:0] RW_IDLE = 2'b00;
  localparam logic [1:0] RW_LDR  = 2'b01;
  localparam logic [1:0] RW_STR  = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } str_state_e;

  function automatic logic is_onehot16(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

endpackage

// File: rtl/str_path_ctrl_if.sv
// Store-request handshake plus RAM write bus; master is the controller side.
interface str_path_ctrl_if #(parameter int ADDR_W = 8);

  logic              str_valid;
  logic              str_ready;
  logic [15:0]       strsrcdec;
  logic [ADDR_W-1:0] str_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic [1:0]        rw;
  logic              ram_ack;

  modport master (
    input  str_valid, strsrcdec, str_addr, ram_ack,
    output str_ready, ram_addr, ram_wdata, ram_we, rw
  );

  modport slave (
    output str_valid, strsrcdec, str_addr, ram_ack,
    input  str_ready, ram_addr, ram_wdata, ram_we, rw
  );

endinterface

// File: rtl/str_fifo.sv
// Request queue: DEPTH entries, full/empty resolved by an extra pointer bit.
module str_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 40
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [PW:0]  r_wr_ptr;
  logic [PW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_din;
  end

endmodule

// File: rtl/str_path_ctrl.sv
// Store path controller: captures register-bank data on accept, queues it and
// sequences single RAM writes with ack timeout.
module str_path_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 4,
  parameter int ACK_TMO = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] q0,  input logic [31:0] q1,  input logic [31:0] q2,  input logic [31:0] q3,
  input  logic [31:0] q4,  input logic [31:0] q5,  input logic [31:0] q6,  input logic [31:0] q7,
  input  logic [31:0] q8,  input logic [31:0] q9,  input logic [31:0] q10, input logic [31:0] q11,
  input  logic [31:0] q12, input logic [31:0] q13, input logic [31:0] q14, input logic [31:0] q15,
  str_path_ctrl_if.master bus,
  output logic        busy,
  output logic        err,
  output logic        tmo,
  output logic [15:0] store_cnt
);

  localparam int TMO_W = $clog2(ACK_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TMO - 1);

  str_state_e          r_state;
  str_state_e          w_state_nxt;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [31:0]         r_ram_wdata;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic [15:0]         r_store_cnt;
  logic                r_err;
  logic                r_tmo;
  logic [31:0]         w_q [16];
  logic [31:0]         w_sel_data;
  logic                w_accept;
  logic                w_sel_ok;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_ack_done;
  logic                w_tmo_hit;
  logic [ADDR_W+31:0]  w_head;

  assign w_q = '{q0, q1, q2, q3, q4, q5, q6, q7, q8, q9, q10, q11, q12, q13, q14, q15};

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < 16; i++) begin
      if (bus.strsrcdec[i]) w_sel_data = w_sel_data | w_q[i];
    end
  end

  assign w_accept = bus.str_valid && bus.str_ready;
  assign w_sel_ok = is_onehot16(bus.strsrcdec);
  assign w_push   = w_accept && w_sel_ok;

  str_fifo #(.DEPTH(DEPTH), .W(ADDR_W + 32)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   ({bus.str_addr, w_sel_data}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.str_ready = !w_full;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_ack_done  = 1'b0;
    w_tmo_hit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.ram_ack) begin
          w_ack_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_tmo_cnt == '0) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Timer reloads on every pop and counts down once per ack-less WRITE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_tmo_cnt   <= '0;
      r_store_cnt <= '0;
      r_err       <= 1'b0;
      r_tmo       <= 1'b0;
    end else begin
      if (w_pop) begin
        {r_ram_addr, r_ram_wdata} <= w_head;
        r_tmo_cnt                 <= TMO_LOAD;
      end else if (r_state == ST_WRITE && !bus.ram_ack && r_tmo_cnt != '0) begin
        r_tmo_cnt <= r_tmo_cnt - 1'b1;
      end
      if (w_ack_done) r_store_cnt <= r_store_cnt + 16'd1;
      r_err <= w_accept && !w_sel_ok;
      r_tmo <= w_tmo_hit;
    end
  end

  assign bus.ram_we    = (r_state == ST_WRITE);
  assign bus.rw        = (r_state == ST_WRITE) ? RW_STR : RW_IDLE;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign busy          = (r_state == ST_WRITE);
  assign err           = r_err;
  assign tmo           = r_tmo;
  assign store_cnt     = r_store_cnt;

endmodule

// File: tb/tb_str_path_ctrl.sv
// Self-checking bench for str_path_ctrl: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_str_path_ctrl;

  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 4;
  localparam int ACK_TMO = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] q [16];
  logic        busy, err, tmo;
  logic [15:0] store_cnt;

  str_path_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  str_path_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .ACK_TMO(ACK_TMO)) dut (
    .clk(clk), .reset(reset),
    .q0(q[0]),   .q1(q[1]),   .q2(q[2]),   .q3(q[3]),
    .q4(q[4]),   .q5(q[5]),   .q6(q[6]),   .q7(q[7]),
    .q8(q[8]),   .q9(q[9]),   .q10(q[10]), .q11(q[11]),
    .q12(q[12]), .q13(q[13]), .q14(q[14]), .q15(q[15]),
    .bus(bus),
    .busy(busy), .err(err), .tmo(tmo), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending queue, one in-flight write, cycle age of that write.
  ent_t        m_q[$];
  bit          m_busy = 1'b0;
  ent_t        m_cur  = '0;
  int          m_age  = 0;
  logic [15:0] m_cnt  = '0;
  bit          m_err  = 1'b0;
  bit          m_tmo  = 1'b0;
  bit          m_live = 1'b0;

  always @(posedge clk) begin : model
    int   sz;
    bit   acc, ok;
    ent_t e;
    if (reset) begin
      m_q.delete();
      m_busy = 1'b0; m_cur = '0; m_age = 0; m_cnt = '0;
      m_err = 1'b0; m_tmo = 1'b0; m_live = 1'b1;
    end else if (m_live) begin
      sz    = m_q.size();
      acc   = bus.str_valid && (sz < DEPTH);
      ok    = ($countones(bus.strsrcdec) == 1);
      m_err = acc && !ok;
      m_tmo = 1'b0;
      if (m_busy) begin
        m_age++;
        if (bus.ram_ack) begin
          m_busy = 1'b0;
          m_cnt  = m_cnt + 16'd1;
        end else if (m_age == ACK_TMO) begin
          m_busy = 1'b0;
          m_tmo  = 1'b1;
        end
      end else if (sz > 0) begin
        m_cur  = m_q.pop_front();
        m_busy = 1'b1;
        m_age  = 0;
      end
      if (acc && ok) begin
        e.a = bus.str_addr;
        e.d = '0;
        for (int i = 0; i < 16; i++) if (bus.strsrcdec[i]) e.d = q[i];
        m_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("ram_we",    bus.ram_we,    m_busy);
      check("busy",      busy,          m_busy);
      check("rw",        bus.rw,        m_busy ? 2'b10 : 2'b00);
      check("ram_addr",  bus.ram_addr,  m_cur.a);
      check("ram_wdata", bus.ram_wdata, m_cur.d);
      check("str_ready", bus.str_ready, m_q.size() < DEPTH);
      check("store_cnt", store_cnt,     m_cnt);
      check("err",       err,           m_err);
      check("tmo",       tmo,           m_tmo);
    end
  end

  // RAM responder and observers; runs after the driver each cycle.
  int   ack_mode  = 0;
  int   ack_delay = 1;
  int   wcyc      = 0;
  int   tmo_seen  = 0;
  int   err_seen  = 0;
  int   we_run    = 0;
  int   last_run  = 0;
  ent_t dlog[$];

  always @(negedge clk) begin : responder
    logic ack;
    ent_t e;
    #2;
    if (bus.ram_we) wcyc++; else wcyc = 0;
    case (ack_mode)
      0:       ack = 1'b0;
      1:       ack = bus.ram_we && (wcyc >= ack_delay);
      2:       ack = (($urandom % 3) == 0);
      default: ack = (($urandom % 20) == 0);
    endcase
    bus.ram_ack = ack;
    if (bus.ram_we && bus.ram_ack && !reset) begin
      e.a = bus.ram_addr;
      e.d = bus.ram_wdata;
      dlog.push_back(e);
    end
    if (tmo) tmo_seen++;
    if (err) err_seen++;
    if (bus.ram_we) we_run++;
    else begin
      if (we_run > 0) last_run = we_run;
      we_run = 0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] dec, input logic [7:0] addr, input int src,
                      input logic [31:0] val);
    bit ok;
    if (src >= 0) q[src] = val;
    bus.strsrcdec = dec;
    bus.str_addr  = addr;
    bus.str_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      if (bus.str_ready) ok = 1'b1;
      step();
    end
    bus.str_valid = 1'b0;
    check("send_accept", ok, 1'b1);
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int t = 0; t < budget && dlog.size() < n; t++) step();
    check("log_wait", dlog.size() >= n, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, acc, e0, t0;
    reset = 1'b1;
    bus.str_valid = 1'b0;
    bus.strsrcdec = '0;
    bus.str_addr  = '0;
    bus.ram_ack   = 1'b0;
    for (int i = 0; i < 16; i++) q[i] = '0;
    step(); step();
    check("rst_ready",  bus.str_ready, 1'b1);
    check("rst_we",     bus.ram_we,    1'b0);
    check("rst_rw",     bus.rw,        2'b00);
    check("rst_addr",   bus.ram_addr,  8'h00);
    check("rst_wdata",  bus.ram_wdata, 32'h0);
    check("rst_cnt",    store_cnt,     16'd0);
    reset = 1'b0;
    step();

    // single store with one-cycle ack delay
    ack_mode = 1; ack_delay = 2;
    send(16'h0008, 8'h10, 3, 32'hDEADBEEF);
    check("lat_edge_n",  bus.ram_we, 1'b0);
    step();
    check("lat_edge_n1", bus.ram_we, 1'b1);
    check("rw_write",    bus.rw,     2'b10);
    wait_log(1, 30);
    step();
    check("single_addr", dlog[0].a, 8'h10);
    check("single_data", dlog[0].d, 32'hDEADBEEF);
    check("single_cnt",  store_cnt, 16'd1);

    // backpressure: one write in flight plus four queued fills the path
    ack_mode = 0;
    base = dlog.size();
    acc  = 0;
    bus.str_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      q[i] = 32'h100 + i;
      bus.strsrcdec = 16'(1 << i);
      bus.str_addr  = 8'(8'h20 + i);
      if (bus.str_ready) acc++;
      step();
    end
    bus.strsrcdec = 16'h0040;
    bus.str_addr  = 8'h99;
    check("bp_accepts",   acc,           5);
    check("bp_ready_low", bus.str_ready, 1'b0);
    step();
    bus.str_valid = 1'b0;
    check("bp_still_low", bus.str_ready, 1'b0);
    ack_mode = 1; ack_delay = 1;
    wait_log(base + 5, 80);
    for (int i = 0; i < 5; i++) begin
      check("bp_order_addr", dlog[base+i].a, 8'(8'h20 + i));
      check("bp_order_data", dlog[base+i].d, 32'h100 + i);
    end
    step();
    check("bp_cnt", store_cnt, 16'd6);

    // data is captured at accept, not at write
    ack_mode = 0;
    base = dlog.size();
    send(16'h0020, 8'h30, 5, 32'h1);
    q[5] = 32'h2;
    step(); step();
    check("dat_wdata_held", bus.ram_wdata, 32'h1);
    ack_mode = 1;
    wait_log(base + 1, 30);
    check("dat_log", dlog[base].d, 32'h1);
    step();

    // bad select is dropped with an err pulse
    base = dlog.size();
    e0   = err_seen;
    send(16'h0011, 8'h50, 0, 32'h55);
    repeat (5) step();
    check("bad_err_pulses", err_seen - e0, 1);
    check("bad_no_write",   dlog.size(),   base);
    check("bad_cnt",        store_cnt,     16'd7);

    // ack timeout, then the next queued store proceeds
    ack_mode = 0;
    base = dlog.size();
    t0   = tmo_seen;
    send(16'h0001, 8'h40, 0, 32'hAAAA0000);
    send(16'h0002, 8'h41, 1, 32'hBBBB0000);
    for (int t = 0; t < 40 && tmo_seen == t0; t++) step();
    check("tmo_pulses",   tmo_seen - t0, 1);
    check("tmo_we_cycles", last_run,     ACK_TMO);
    ack_mode = 1; ack_delay = 1;
    wait_log(base + 1, 30);
    check("tmo_next_addr", dlog[base].a, 8'h41);
    check("tmo_next_data", dlog[base].d, 32'hBBBB0000);
    step();
    check("tmo_cnt", store_cnt, 16'd8);

    // reset during a write with three more queued
    ack_mode = 0;
    for (int i = 0; i < 4; i++) send(16'(1 << (i + 8)), 8'(8'h60 + i), i + 8, 32'hC0 + i);
    check("rst_mid_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_we",    bus.ram_we,    1'b0);
    check("rst_mid_ready", bus.str_ready, 1'b1);
    check("rst_mid_cnt",   store_cnt,     16'd0);
    base = dlog.size();
    ack_mode = 1;
    repeat (10) step();
    check("rst_mid_empty", dlog.size(), base);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ((c % 64) == 0) ack_mode = 2 + int'($urandom % 2);
      reset         = (($urandom % 250) == 0);
      bus.str_valid = $urandom % 2;
      bus.strsrcdec = (($urandom % 8) == 0) ? 16'($urandom) : 16'(1 << ($urandom % 16));
      bus.str_addr  = 8'($urandom);
      q[$urandom % 16] = $urandom;
      step();
    end
    reset = 1'b0;
    bus.str_valid = 1'b0;
    ack_mode = 1; ack_delay = 1;
    repeat (50) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
